fir_filter_mc_pipelined: RTL and testbench

- Parametrised, multi-channel, pipelined FIR filter. Successor to the fixed 7-tap dual-stream filter.
- NCH independent sample streams share one runtime-loadable coefficient set.
- Coefficient set is double-buffered and swapped atomically only after a correctly framed load. Malformed loads are rejected and flagged.
- Sits between the sample source and downstream accumulation/decimation logic in the course DSP datapath.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_channel_datapath.sv | 77 +++++++
 rtl/fir_filter_mc_pipelined.sv | 130 +++++++++++++
 tb/tb_fir_filter_mc_pipelined.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Width derivation and sign/zero extension shared by the FIR top and its channel datapaths.
package fir_pkg;

  localparam int unsigned EXT_W = 64;

  function automatic int calc_ow(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  function automatic int calc_iw(input int ntaps);
    return $clog2(ntaps + 1);
  endfunction

  // Treats the low w bits of v as a value and extends it to EXT_W bits, sign-extending when sgn is set.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] v, input int w, input logic sgn);
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] r;
    mask = {EXT_W{1'b1}} << w;
    r    = v & ~mask;
    if (sgn && v[6'(w - 1)]) r = r | mask;
    return r;
  endfunction

endpackage

// File: rtl/fir_channel_datapath.sv
// One FIR channel: delay line, registered products, registered adder tree; 3 cycles sample to y.
// No backpressure; y holds its value on cycles when no new result is produced.
module fir_channel_datapath
  import fir_pkg::*;
#(
  parameter int NTAPS  = 7,
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int SIGNED = 0,
  parameter int OW     = calc_ow(DW, CW, NTAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic [DW-1:0]       x_in,
  input  logic                prod_en,
  input  logic [NTAPS*CW-1:0] coef,
  input  logic                sum_en,
  output logic [OW-1:0]       y_out
);

  localparam int   PW  = DW + CW;
  localparam logic SGN = (SIGNED != 0);

  logic [DW-1:0] dly_q  [NTAPS];
  logic [DW-1:0] dly_d  [NTAPS];
  logic [PW-1:0] prod_q [NTAPS];
  logic [PW-1:0] prod_d [NTAPS];
  logic [OW-1:0] y_q;
  logic [OW-1:0] y_d;

  always_comb begin
    logic [PW-1:0] c_ext;
    logic [PW-1:0] d_ext;
    logic [OW-1:0] acc;
    c_ext = '0;
    d_ext = '0;
    acc   = '0;
    for (int k = 0; k < NTAPS; k++) begin
      dly_d[k]  = dly_q[k];
      prod_d[k] = prod_q[k];
    end
    if (shift_en) begin
      dly_d[0] = x_in;
      for (int k = 1; k < NTAPS; k++) dly_d[k] = dly_q[k-1];
    end
    // Operands extended to PW first so the truncated product is exact in either mode.
    if (prod_en) begin
      for (int k = 0; k < NTAPS; k++) begin
        c_ext     = PW'(ext(EXT_W'(coef[k*CW +: CW]), CW, SGN));
        d_ext     = PW'(ext(EXT_W'(dly_q[k]), DW, SGN));
        prod_d[k] = c_ext * d_ext;
      end
    end
    for (int k = 0; k < NTAPS; k++) acc = acc + OW'(ext(EXT_W'(prod_q[k]), PW, SGN));
    y_d = sum_en ? acc : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        dly_q[k]  <= '0;
        prod_q[k] <= '0;
      end
      y_q <= '0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        dly_q[k]  <= dly_d[k];
        prod_q[k] <= prod_d[k];
      end
      y_q <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: rtl/fir_filter_mc_pipelined.sv
// NCH-channel FIR sharing a double-buffered, frame-checked coefficient set; in_valid to out_valid is 3 cycles.
// No backpressure: every out_valid cycle must be consumed downstream.
module fir_filter_mc_pipelined
  import fir_pkg::*;
#(
  parameter int NTAPS  = 7,
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int NCH    = 2,
  parameter int SIGNED = 0,
  parameter int OW     = calc_ow(DW, CW, NTAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW-1:0]     coef_val,
  input  logic              coef_wr,
  input  logic              coef_last,
  output logic              coef_active,
  output logic              coef_err,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] x_in,
  output logic              out_valid,
  output logic [NCH*OW-1:0] y_out
);

  localparam int            IW       = calc_iw(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(NTAPS);

  logic [IW-1:0]       wi_q, wi_d;
  logic                bad_q, bad_d;
  logic                err_q, err_d;
  logic                act_q, act_d;
  logic                v0_q, v0_d;
  logic                vp_q, vp_d;
  logic                ov_q, ov_d;
  logic [CW-1:0]       shadow_q [NTAPS];
  logic [CW-1:0]       shadow_d [NTAPS];
  logic [CW-1:0]       bank_q   [NTAPS];
  logic [CW-1:0]       bank_d   [NTAPS];
  logic [NTAPS*CW-1:0] bank_flat;

  always_comb begin
    wi_d  = wi_q;
    bad_d = bad_q;
    err_d = 1'b0;
    act_d = act_q;
    for (int k = 0; k < NTAPS; k++) begin
      shadow_d[k] = shadow_q[k];
      bank_d[k]   = bank_q[k];
    end
    if (coef_wr) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (wi_q == IW'(k)) shadow_d[k] = coef_val;
      end
      if (coef_last) begin
        wi_d  = '0;
        bad_d = 1'b0;
        // The final word bypasses the shadow so the whole set lands in the active bank on this edge.
        if (!bad_q && wi_q == LAST_IDX) begin
          for (int k = 0; k < NTAPS - 1; k++) bank_d[k] = shadow_q[k];
          bank_d[NTAPS-1] = coef_val;
          act_d           = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (wi_q == FULL_IDX) begin
        bad_d = 1'b1;
      end else begin
        wi_d = wi_q + IW'(1);
      end
    end
    v0_d = in_valid;
    vp_d = v0_q & act_q;
    ov_d = vp_q;
    bank_flat = '0;
    for (int k = 0; k < NTAPS; k++) bank_flat[k*CW +: CW] = bank_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wi_q  <= '0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      act_q <= 1'b0;
      v0_q  <= 1'b0;
      vp_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      wi_q  <= wi_d;
      bad_q <= bad_d;
      err_q <= err_d;
      act_q <= act_d;
      v0_q  <= v0_d;
      vp_q  <= vp_d;
      ov_q  <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NTAPS; k++) begin
      shadow_q[k] <= shadow_d[k];
      bank_q[k]   <= bank_d[k];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fir_channel_datapath #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .CW    (CW),
      .SIGNED(SIGNED),
      .OW    (OW)
    ) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .shift_en(in_valid),
      .x_in    (x_in[c*DW +: DW]),
      .prod_en (vp_d),
      .coef    (bank_flat),
      .sum_en  (vp_q),
      .y_out   (y_out[c*OW +: OW])
    );
  end

  assign coef_active = act_q;
  assign coef_err    = err_q;
  assign out_valid   = ov_q;

endmodule

// File: tb/tb_fir_filter_mc_pipelined.sv
// Bench for fir_filter_mc_pipelined: unsigned and signed instances, vector tables plus a
// cycle-stamped scoreboard per instance checking value, latency and hold behaviour.
module tb_fir_filter_mc_pipelined;

  typedef struct {
    logic [37:0] y;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0]  x0;
    logic [7:0]  x1;
    logic [18:0] e0;
    logic [18:0] e1;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  coef_val, s_coef_val;
  logic        coef_wr, coef_last, s_coef_wr, s_coef_last;
  logic        coef_active, coef_err, s_coef_active, s_coef_err;
  logic        in_valid, s_in_valid;
  logic [15:0] x_in, s_x_in;
  logic        out_valid, s_out_valid;
  logic [37:0] y_out, s_y_out;

  fir_filter_mc_pipelined #(.NTAPS(7), .DW(8), .CW(8), .NCH(2), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .coef_val(coef_val), .coef_wr(coef_wr), .coef_last(coef_last),
    .coef_active(coef_active), .coef_err(coef_err), .in_valid(in_valid), .x_in(x_in),
    .out_valid(out_valid), .y_out(y_out)
  );

  fir_filter_mc_pipelined #(.NTAPS(7), .DW(8), .CW(8), .NCH(2), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .coef_val(s_coef_val), .coef_wr(s_coef_wr), .coef_last(s_coef_last),
    .coef_active(s_coef_active), .coef_err(s_coef_err), .in_valid(s_in_valid), .x_in(s_x_in),
    .out_valid(s_out_valid), .y_out(s_y_out)
  );

  exp_t        q  [$];
  exp_t        qs [$];
  logic [37:0] last_y  = '0;
  logic [37:0] last_ys = '0;
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        imp [10];
  vec_t        gap [8];
  vec_t        sv  [3];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input logic [18:0] e0, input logic [18:0] e1);
    exp_t e;
    e.y   = {e1, e0};
    e.due = cyc + 3;
    if (which == 0) q.push_back(e);
    else qs.push_back(e);
  endtask

  // mode 0: val+i, mode 1: constant val, mode 2: val then zeros.
  task automatic load_frame(input int which, input int n, input int mode, input logic [7:0] val);
    for (int i = 0; i < n; i++) begin
      logic [7:0] w;
      w = (mode == 0) ? val + 8'(i) : (mode == 1) ? val : ((i == 0) ? val : 8'h00);
      if (which == 0) begin
        coef_wr = 1'b1; coef_val = w; coef_last = (i == n - 1);
      end else begin
        s_coef_wr = 1'b1; s_coef_val = w; s_coef_last = (i == n - 1);
      end
      tick();
    end
    coef_wr = 1'b0; coef_last = 1'b0; s_coef_wr = 1'b0; s_coef_last = 1'b0;
  endtask

  task automatic apply_imp();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x_in     = {imp[i].x1, imp[i].x0};
      push(0, imp[i].e0, imp[i].e1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (q.size() != 0 || qs.size() != 0); i++) tick();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'(0));
        else begin
          exp_t e;
          e = q.pop_front();
          check("y_out", 64'(y_out), 64'(e.y));
          check("out_latency", 64'(cyc), 64'(e.due));
          last_y = e.y;
        end
      end else begin
        check("y_out_hold", 64'(y_out), 64'(last_y));
        if (q.size() != 0 && q[0].due < cyc) begin
          check("missing_out_valid", 64'(out_valid), 64'(1));
          void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_out_valid) begin
        if (qs.size() == 0) check("s_unexpected_out_valid", 64'(s_out_valid), 64'(0));
        else begin
          exp_t e;
          e = qs.pop_front();
          check("s_y_out", 64'(s_y_out), 64'(e.y));
          check("s_out_latency", 64'(cyc), 64'(e.due));
          last_ys = e.y;
        end
      end else begin
        check("s_y_out_hold", 64'(s_y_out), 64'(last_ys));
        if (qs.size() != 0 && qs[0].due < cyc) begin
          check("s_missing_out_valid", 64'(s_out_valid), 64'(1));
          void'(qs.pop_front());
        end
      end
    end
  end

  initial begin
    imp[0] = '{8'd1, 8'd0, 19'd1, 19'd0};
    imp[1] = '{8'd0, 8'd0, 19'd2, 19'd0};
    imp[2] = '{8'd0, 8'd0, 19'd3, 19'd0};
    imp[3] = '{8'd0, 8'd0, 19'd4, 19'd0};
    imp[4] = '{8'd0, 8'd0, 19'd5, 19'd0};
    imp[5] = '{8'd0, 8'd0, 19'd6, 19'd0};
    imp[6] = '{8'd0, 8'd0, 19'd7, 19'd0};
    imp[7] = '{8'd0, 8'd0, 19'd0, 19'd0};
    imp[8] = '{8'd0, 8'd0, 19'd0, 19'd0};
    imp[9] = '{8'd0, 8'd0, 19'd0, 19'd0};
    gap[0] = '{8'd1, 8'd1, 19'd1, 19'd1};
    gap[1] = '{8'd1, 8'd1, 19'd2, 19'd2};
    gap[2] = '{8'd1, 8'd1, 19'd3, 19'd3};
    gap[3] = '{8'd1, 8'd1, 19'd4, 19'd4};
    gap[4] = '{8'd1, 8'd1, 19'd5, 19'd5};
    gap[5] = '{8'd1, 8'd1, 19'd6, 19'd6};
    gap[6] = '{8'd1, 8'd1, 19'd7, 19'd7};
    gap[7] = '{8'd1, 8'd1, 19'd7, 19'd7};
    sv[0]  = '{8'h02, 8'h7F, 19'h7FFFE, 19'h7FF81};
    sv[1]  = '{8'hFE, 8'h00, 19'h00002, 19'h00000};
    sv[2]  = '{8'h80, 8'h01, 19'h00080, 19'h7FFFF};

    rst_n = 1'b0;
    coef_val = '0; coef_wr = 1'b0; coef_last = 1'b0; in_valid = 1'b0; x_in = '0;
    s_coef_val = '0; s_coef_wr = 1'b0; s_coef_last = 1'b0; s_in_valid = 1'b0; s_x_in = '0;
    #12;
    check("rst_coef_active", 64'(coef_active), 64'(0));
    check("rst_coef_err", 64'(coef_err), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_y_out", 64'(y_out), 64'(0));
    check("rst_s_coef_active", 64'(s_coef_active), 64'(0));
    check("rst_s_coef_err", 64'(s_coef_err), 64'(0));
    rst_n = 1'b1;
    tick();

    // Impulse response with coefficients 1..7.
    load_frame(0, 7, 0, 8'd1);
    check("load_active", 64'(coef_active), 64'(1));
    check("load_no_err", 64'(coef_err), 64'(0));
    apply_imp();
    drain();

    // Short and overrun frames must be rejected without touching the active bank.
    load_frame(0, 5, 1, 8'd3);
    check("short_err", 64'(coef_err), 64'(1));
    check("short_keeps_active", 64'(coef_active), 64'(1));
    tick();
    check("short_err_pulse_end", 64'(coef_err), 64'(0));
    apply_imp();
    drain();
    load_frame(0, 9, 1, 8'd9);
    check("long_err", 64'(coef_err), 64'(1));
    tick();
    check("long_err_pulse_end", 64'(coef_err), 64'(0));
    apply_imp();
    drain();

    // Full scale: ramp as the delay line fills, then 7*255*255.
    load_frame(0, 7, 1, 8'd255);
    check("full_no_err", 64'(coef_err), 64'(0));
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1;
      x_in     = 16'hFFFF;
      push(0, 19'(65025 * ((i < 7) ? i : 7)), 19'(65025 * ((i < 7) ? i : 7)));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Reset while streaming and while a frame is half loaded.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x_in = 16'hFFFF;
      coef_wr  = 1'b1; coef_val = 8'd2; coef_last = 1'b0;
      push(0, 19'd455175, 19'd455175);
      tick();
    end
    in_valid = 1'b0; coef_wr = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete(); qs.delete(); last_y = '0; last_ys = '0;
    #1;
    check("midrst_coef_active", 64'(coef_active), 64'(0));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_y_out", 64'(y_out), 64'(0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // Streaming with no accepted load: old bank must stay unused.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      x_in     = (i < 10) ? 16'h0505 : 16'h0000;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("noload_out_valid", 64'(out_valid), 64'(0));
    check("noload_y_out", 64'(y_out), 64'(0));
    check("noload_coef_active", 64'(coef_active), 64'(0));

    // All-ones coefficients, samples on alternate cycles.
    load_frame(0, 7, 1, 8'd1);
    check("ones_active", 64'(coef_active), 64'(1));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      x_in     = {gap[i].x1, gap[i].x0};
      push(0, gap[i].e0, gap[i].e1);
      tick();
      in_valid = 1'b0;
      x_in     = 16'h3C3C;
      tick();
    end
    drain();

    // Signed instance: coef[0] = -1, remaining taps zero.
    load_frame(1, 7, 2, 8'hFF);
    check("s_load_active", 64'(s_coef_active), 64'(1));
    check("s_load_no_err", 64'(s_coef_err), 64'(0));
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1;
      s_x_in     = {sv[i].x1, sv[i].x0};
      push(1, sv[i].e0, sv[i].e1);
      tick();
    end
    s_in_valid = 1'b0;
    drain();
    check("scoreboards_empty", 64'(q.size() + qs.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
